// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared types, func3 codes and access-size decode for the load/store unit
package riscv_lsu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;
  localparam logic [2:0] FUNCT3_LOAD_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LOAD_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LOAD_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LOAD_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LOAD_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_STORE_SB = 3'b000;
  localparam logic [2:0] FUNCT3_STORE_SH = 3'b001;
  localparam logic [2:0] FUNCT3_STORE_SW = 3'b010;
  // Unknown func3 codes fall through to word size
  function automatic lsu_size_e size_of(input logic [2:0] f, input logic st);
    return (f[1] | (st & f[2])) ? SZ_W : f[0] ? SZ_H : SZ_B;
  endfunction
endpackage

// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: req/gnt + rvalid data-memory bus between the LSU (master) and memory (slave)
interface riscv_lsu_if;
  import riscv_lsu_pkg::*;
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  modport master(output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: byte enables, store lane replication, load shift/extension; misalign flag
// only computed when RISCV_LSU_MISALIGN_CHK_EN is defined
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]      st_addr,
  input  logic [2:0]      st_func3,
  input  logic            st_store,
  input  logic [XLEN-1:0] st_data,
  input  logic [1:0]      ld_addr,
  input  logic [2:0]      ld_func3,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data,
  output logic            mis
);
  lsu_size_e       st_sz, ld_sz;
  logic [XLEN-1:0] sh;
  logic            sgn;
  always_comb begin
    st_sz = size_of(st_func3, st_store);
    ld_sz = size_of(ld_func3, 1'b0);
    be = st_sz == SZ_B ? 4'b0001 << st_addr : st_sz == SZ_H ? 4'b0011 << {st_addr[1], 1'b0} : 4'b1111;
    wdata = st_sz == SZ_B ? {4{st_data[7:0]}} : st_sz == SZ_H ? {2{st_data[15:0]}} : st_data;
`ifdef RISCV_LSU_MISALIGN_CHK_EN
    mis = st_sz == SZ_H ? st_addr[0] : st_sz == SZ_W && st_addr != 2'b00;
`else
    mis = 1'b0;
`endif
    // Halves drop a[0] so the lane choice matches the store byte enables
    sh = ld_sz == SZ_H ? ld_rdata >> {ld_addr[1], 4'b0} : ld_rdata >> {ld_addr, 3'b0};
    sgn = ~ld_func3[2];
    ld_data = ld_sz == SZ_B ? {{(XLEN-8){sgn & sh[7]}}, sh[7:0]} :
              ld_sz == SZ_H ? {{(XLEN-16){sgn & sh[15]}}, sh[15:0]} : ld_rdata;
  end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: M-stage load/store unit with request latches, access FSM and timeout counter.
// Define RISCV_LSU_MISALIGN_CHK_EN to trap misaligned H/W accesses without touching the bus.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [XLEN-1:0]  i_lsu_addr,
  input  logic [XLEN-1:0]  i_lsu_wr_data,
  input  logic             i_lsu_wr_en,
  input  logic             i_lsu_rd_en,
  input  logic [2:0]       i_lsu_func3,
  output logic [XLEN-1:0]  o_lsu_rd_data,
  output logic             o_lsu_stall,
  output logic             o_lsu_bus_err,
  output logic             o_lsu_misalign,
  riscv_lsu_if.master      bus
);
  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES - 1);
  lsu_state_e      state;
  logic [7:0]      cnt;
  logic [2:0]      func3_q;
  logic [1:0]      alo_q;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata, ld_data;
  logic            mis;
  logic            access;
  riscv_lsu_align u_align (
    .st_addr(i_lsu_addr[1:0]), .st_func3(i_lsu_func3), .st_store(i_lsu_wr_en), .st_data(i_lsu_wr_data),
    .ld_addr(alo_q), .ld_func3(func3_q), .ld_rdata(bus.rdata),
    .be(be), .wdata(wdata), .ld_data(ld_data), .mis(mis)
  );
  assign access = i_lsu_wr_en | i_lsu_rd_en;
  // DONE releases the pipeline so the instruction retires at that edge
  assign o_lsu_stall = state == LSU_IDLE ? access : state != LSU_DONE;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= LSU_IDLE;
      cnt <= '0;
      func3_q <= '0;
      alo_q <= '0;
      o_lsu_rd_data <= '0;
      o_lsu_bus_err <= 1'b0;
      o_lsu_misalign <= 1'b0;
      bus.req <= 1'b0;
      bus.we <= 1'b0;
      bus.addr <= '0;
      bus.wdata <= '0;
      bus.be <= '0;
    end else begin
      o_lsu_bus_err <= 1'b0;
      o_lsu_misalign <= 1'b0;
      case (state)
        LSU_IDLE: if (access) begin
          if (mis) begin
            state <= LSU_DONE;
            o_lsu_misalign <= 1'b1;
            o_lsu_rd_data <= '0;
          end else begin
            state <= LSU_REQ;
            bus.req <= 1'b1;
            bus.we <= i_lsu_wr_en;
            bus.addr <= {i_lsu_addr[XLEN-1:2], 2'b00};
            bus.wdata <= wdata;
            bus.be <= be;
            func3_q <= i_lsu_func3;
            alo_q <= i_lsu_addr[1:0];
          end
        end
        LSU_REQ: if (bus.gnt) begin
          bus.req <= 1'b0;
          cnt <= '0;
          state <= bus.we ? LSU_DONE : LSU_WAIT;
        end
        LSU_WAIT: begin
          if (bus.rvalid) begin
            o_lsu_rd_data <= ld_data;
            state <= LSU_DONE;
          end else if (cnt == TMAX) begin
            o_lsu_rd_data <= '0;
            o_lsu_bus_err <= 1'b1;
            state <= LSU_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LSU_DONE: state <= LSU_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: scoreboard bench for riscv_lsu; a bus responder task plays memory with
// configurable gnt/rvalid delays and the scenario tasks compare what it saw against the queue.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;
  localparam int TO = 255;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr, wd, rd_data;
  logic        wr, rd, stall, err, mis;
  logic [2:0]  f3;
  int          n_vec = 0, n_err = 0;
  riscv_lsu_if bus ();
  riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_lsu_addr(addr), .i_lsu_wr_data(wd), .i_lsu_wr_en(wr),
    .i_lsu_rd_en(rd), .i_lsu_func3(f3), .o_lsu_rd_data(rd_data), .o_lsu_stall(stall),
    .o_lsu_bus_err(err), .o_lsu_misalign(mis), .bus(bus)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] baddr, bwdata, rd;
    logic [3:0]  be;
    logic        we, req, err, mis;
    int          stalls;
  } rec_t;
  rec_t exp_q[$];
  rec_t ob;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, d, bw;
    logic [3:0]  be;
    int          g;
  } st_t;
  st_t st_tab[3] = '{
    '{FUNCT3_STORE_SW, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 0},
    '{FUNCT3_STORE_SB, 32'h103, 32'h000000A5, 32'hA5A5A5A5, 4'b1000, 2},
    '{FUNCT3_STORE_SH, 32'h10A, 32'h1234BEEF, 32'hBEEFBEEF, 4'b1100, 1}
  };

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, rdat, res;
    logic [3:0]  be;
    int          rdly;
    logic        rvg;
  } ld_t;
  ld_t ld_tab[5] = '{
    '{FUNCT3_LOAD_LB,  32'h101, 32'h00008000, 32'hFFFFFF80, 4'b0010, 3, 1'b0},
    '{FUNCT3_LOAD_LHU, 32'h102, 32'h80010000, 32'h00008001, 4'b1100, 0, 1'b1},
    '{FUNCT3_LOAD_LH,  32'h102, 32'h80010000, 32'hFFFF8001, 4'b1100, 1, 1'b0},
    '{FUNCT3_LOAD_LBU, 32'h103, 32'h9A000000, 32'h0000009A, 4'b1000, 2, 1'b0},
    '{FUNCT3_LOAD_LW,  32'h104, 32'h12345678, 32'h12345678, 4'b1111, 0, 1'b1}
  };

  // Drives one access and plays memory; results land in ob when the DONE cycle is seen
  task automatic access(input logic w, r, input logic [31:0] a, d, input logic [2:0] f,
                        input int gdly, rdly, input logic [31:0] rdat, input logic rv_at_gnt);
    int   gcnt = 0, wcnt = 0, cyc = 0;
    logic granted = 1'b0;
    ob = '{default: '0};
    @(posedge clk);
    #1;
    wr = w; rd = r; addr = a; wd = d; f3 = f;
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 600) begin
        n_vec++; n_err++;
        $display("FAIL access_bound no DONE after %0d cycles, required DONE", cyc);
        break;
      end
      bus.gnt = 1'b0;
      bus.rvalid = 1'b0;
      if (stall) ob.stalls++;
      else if (ob.stalls > 0) begin
        ob.rd = rd_data; ob.err = err; ob.mis = mis;
        break;
      end
      if (bus.req) begin
        ob.req = 1'b1; ob.baddr = bus.addr; ob.be = bus.be; ob.we = bus.we; ob.bwdata = bus.wdata;
        if (gcnt == gdly) begin
          bus.gnt = 1'b1;
          granted = 1'b1;
          if (rv_at_gnt) begin bus.rvalid = 1'b1; bus.rdata = ~rdat; end
        end
        gcnt++;
      end else if (stall && granted) begin
        if (rdly >= 0 && wcnt == rdly) begin bus.rvalid = 1'b1; bus.rdata = rdat; end
        wcnt++;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b need 0", bus.req); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b need 0", stall); end
    n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd got %h need 0", rd_data); end
    n_vec++; if ({err, mis, bus.we, bus.be} !== 7'h0) begin n_err++; $display("FAIL reset_flags got %b need 0", {err, mis, bus.we, bus.be}); end
    n_vec++; if ({bus.addr, bus.wdata} !== 64'h0) begin n_err++; $display("FAIL reset_bus got %h need 0", {bus.addr, bus.wdata}); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stores();
    rec_t e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{baddr: {st_tab[i].a[31:2], 2'b00}, bwdata: st_tab[i].bw, rd: 32'h0, be: st_tab[i].be,
                        we: 1'b1, req: 1'b1, err: 1'b0, mis: 1'b0, stalls: 2 + st_tab[i].g});
      access(1'b1, 1'b0, st_tab[i].a, st_tab[i].d, st_tab[i].f, st_tab[i].g, -1, 32'h0, 1'b0);
      e = exp_q.pop_front();
      n_vec++; if (ob.baddr !== e.baddr) begin n_err++; $display("FAIL st%0d_addr got %h need %h", i, ob.baddr, e.baddr); end
      n_vec++; if (ob.be !== e.be) begin n_err++; $display("FAIL st%0d_be got %b need %b", i, ob.be, e.be); end
      n_vec++; if (ob.we !== e.we) begin n_err++; $display("FAIL st%0d_we got %b need %b", i, ob.we, e.we); end
      n_vec++; if (ob.bwdata !== e.bwdata) begin n_err++; $display("FAIL st%0d_wdata got %h need %h", i, ob.bwdata, e.bwdata); end
      n_vec++; if (ob.stalls !== e.stalls) begin n_err++; $display("FAIL st%0d_stall got %0d need %0d", i, ob.stalls, e.stalls); end
    end
    idle();
  endtask

  task automatic test_loads();
    rec_t e;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{baddr: {ld_tab[i].a[31:2], 2'b00}, bwdata: 32'h0, rd: ld_tab[i].res, be: ld_tab[i].be,
                        we: 1'b0, req: 1'b1, err: 1'b0, mis: 1'b0, stalls: 3 + ld_tab[i].rdly});
      access(1'b0, 1'b1, ld_tab[i].a, 32'h0, ld_tab[i].f, 0, ld_tab[i].rdly, ld_tab[i].rdat, ld_tab[i].rvg);
      e = exp_q.pop_front();
      n_vec++; if (ob.rd !== e.rd) begin n_err++; $display("FAIL ld%0d_data got %h need %h", i, ob.rd, e.rd); end
      n_vec++; if (ob.baddr !== e.baddr) begin n_err++; $display("FAIL ld%0d_addr got %h need %h", i, ob.baddr, e.baddr); end
      n_vec++; if (ob.be !== e.be) begin n_err++; $display("FAIL ld%0d_be got %b need %b", i, ob.be, e.be); end
      n_vec++; if (ob.we !== e.we) begin n_err++; $display("FAIL ld%0d_we got %b need %b", i, ob.we, e.we); end
      n_vec++; if (ob.stalls !== e.stalls) begin n_err++; $display("FAIL ld%0d_stall got %0d need %0d", i, ob.stalls, e.stalls); end
      n_vec++; if (ob.err !== e.err) begin n_err++; $display("FAIL ld%0d_err got %b need %b", i, ob.err, e.err); end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    rec_t e;
    exp_q.push_back('{baddr: 32'h80, bwdata: 32'h0, rd: 32'hFFFFFFC3, be: 4'b0001,
                      we: 1'b0, req: 1'b1, err: 1'b0, mis: 1'b0, stalls: 3});
    access(1'b0, 1'b1, 32'h80, 32'h0, FUNCT3_LOAD_LB, 0, 0, 32'h000000C3, 1'b0);
    e = exp_q.pop_front();
    n_vec++; if (ob.rd !== e.rd) begin n_err++; $display("FAIL b2b_load got %h need %h", ob.rd, e.rd); end
    exp_q.push_back('{baddr: 32'h84, bwdata: 32'h55555555, rd: 32'hFFFFFFC3, be: 4'b1111,
                      we: 1'b1, req: 1'b1, err: 1'b0, mis: 1'b0, stalls: 2});
    access(1'b1, 1'b1, 32'h84, 32'h55555555, FUNCT3_STORE_SW, 0, -1, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_vec++; if (ob.we !== e.we) begin n_err++; $display("FAIL b2b_store_wins got %b need %b", ob.we, e.we); end
    n_vec++; if (ob.stalls !== e.stalls) begin n_err++; $display("FAIL b2b_stall got %0d need %0d", ob.stalls, e.stalls); end
    n_vec++; if (ob.rd !== e.rd) begin n_err++; $display("FAIL b2b_rd_held got %h need %h", ob.rd, e.rd); end
    idle();
  endtask

  task automatic test_timeout();
    rec_t e;
    exp_q.push_back('{baddr: 32'h200, bwdata: 32'h0, rd: 32'h0, be: 4'b1111,
                      we: 1'b0, req: 1'b1, err: 1'b1, mis: 1'b0, stalls: 2 + TO});
    access(1'b0, 1'b1, 32'h200, 32'h0, FUNCT3_LOAD_LW, 0, -1, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_vec++; if (ob.err !== e.err) begin n_err++; $display("FAIL to_err got %b need %b", ob.err, e.err); end
    n_vec++; if (ob.rd !== e.rd) begin n_err++; $display("FAIL to_rd got %h need %h", ob.rd, e.rd); end
    n_vec++; if (ob.stalls !== e.stalls) begin n_err++; $display("FAIL to_stall got %0d need %0d", ob.stalls, e.stalls); end
    idle();
    @(negedge clk);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL to_err_pulse got %b need 0", err); end
  endtask

  task automatic test_reset_in_wait();
    rec_t e;
    @(posedge clk);
    #1;
    rd = 1'b1; wr = 1'b0; addr = 32'h300; f3 = FUNCT3_LOAD_LW;
    @(negedge clk);
    @(negedge clk);
    bus.gnt = 1'b1;
    @(negedge clk);
    bus.gnt = 1'b0;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rw_wait_stall got %b need 1", stall); end
    @(negedge clk);
    rd = 1'b0;
    rstn = 1'b0;
    #1;
    n_vec++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL rw_req got %b need 0", bus.req); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rw_stall got %b need 0", stall); end
    n_vec++; if (bus.addr !== 32'h0) begin n_err++; $display("FAIL rw_addr got %h need 0", bus.addr); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if ({stall, bus.req} !== 2'b00) begin n_err++; $display("FAIL rw_idle got %b need 00", {stall, bus.req}); end
    exp_q.push_back('{baddr: 32'h40, bwdata: 32'h00000007, rd: 32'h0, be: 4'b1111,
                      we: 1'b1, req: 1'b1, err: 1'b0, mis: 1'b0, stalls: 2});
    access(1'b1, 1'b0, 32'h40, 32'h7, FUNCT3_STORE_SW, 0, -1, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_vec++; if (ob.baddr !== e.baddr) begin n_err++; $display("FAIL rw_after_addr got %h need %h", ob.baddr, e.baddr); end
    n_vec++; if (ob.stalls !== e.stalls) begin n_err++; $display("FAIL rw_after_stall got %0d need %0d", ob.stalls, e.stalls); end
    idle();
  endtask

  task automatic test_misalign();
    rec_t e;
`ifdef RISCV_LSU_MISALIGN_CHK_EN
    exp_q.push_back('{baddr: 32'h0, bwdata: 32'h0, rd: 32'h0, be: 4'b0000,
                      we: 1'b0, req: 1'b0, err: 1'b0, mis: 1'b1, stalls: 1});
`else
    exp_q.push_back('{baddr: 32'h100, bwdata: 32'h0, rd: 32'hCAFEF00D, be: 4'b1111,
                      we: 1'b0, req: 1'b1, err: 1'b0, mis: 1'b0, stalls: 3});
`endif
    access(1'b0, 1'b1, 32'h102, 32'h0, FUNCT3_LOAD_LW, 0, 0, 32'hCAFEF00D, 1'b0);
    e = exp_q.pop_front();
    n_vec++; if (ob.req !== e.req) begin n_err++; $display("FAIL mis_req got %b need %b", ob.req, e.req); end
    n_vec++; if (ob.mis !== e.mis) begin n_err++; $display("FAIL mis_flag got %b need %b", ob.mis, e.mis); end
    n_vec++; if (ob.rd !== e.rd) begin n_err++; $display("FAIL mis_rd got %h need %h", ob.rd, e.rd); end
    n_vec++; if (ob.stalls !== e.stalls) begin n_err++; $display("FAIL mis_stall got %0d need %0d", ob.stalls, e.stalls); end
    idle();
    @(negedge clk);
    n_vec++; if (mis !== 1'b0) begin n_err++; $display("FAIL mis_pulse got %b need 0", mis); end
  endtask

  initial begin
    wr = 1'b0; rd = 1'b0; addr = '0; wd = '0; f3 = '0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    test_reset();
    test_stores();
    test_loads();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
